// File: rtl/decode_fetch_sequencer.sv
// decode_fetch_sequencer: fetches 8-byte code words into a byte FIFO and presents
// the oldest 15 bytes to the x86-64 decoder, flushing on PC redirects.
module decode_fetch_sequencer #(
    parameter int BUF_BYTES = 32,
    parameter int PC_W      = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            fetch_req_valid,
    output logic [PC_W-1:0] fetch_req_addr,
    input  logic            fetch_req_ready,
    input  logic            fetch_data_valid,
    input  logic [63:0]     fetch_data,
    output logic            fetch_data_ready,
    output logic [0:119]    dec_window,
    output logic            dec_window_valid,
    output logic [PC_W-1:0] dec_pc,
    input  logic            dec_consume,
    input  logic [3:0]      dec_byte_incr,
    output logic            protocol_err
);
    localparam int CW = $clog2(BUF_BYTES) + 1;
    localparam int BW = BUF_BYTES * 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_skip;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_addr;
    logic [BW-1:0]   r_buf;
    logic            r_err;

    logic            w_req_hs;
    logic            w_dat_hs;
    logic            w_owed;
    logic            w_consume;
    logic            w_append;
    logic [3:0]      w_incr;
    logic [CW-1:0]   w_rem;
    logic [CW-1:0]   w_add;
    logic [63:0]     w_word;
    logic [BW-1:0]   w_ins;
    logic [BW-1:0]   w_next_buf;

    assign fetch_req_valid  = r_state == S_REQ && r_count <= CW'(BUF_BYTES - 8);
    assign fetch_data_ready = r_state == S_WAIT || r_state == S_DRAIN;
    assign fetch_req_addr   = r_addr;
    assign dec_window_valid = r_count >= CW'(15) && r_state != S_IDLE;
    assign dec_pc           = r_pc;
    assign protocol_err     = r_err;

    assign w_req_hs  = fetch_req_valid & fetch_req_ready;
    assign w_dat_hs  = fetch_data_valid & fetch_data_ready;
    // A response is still owed if a request was just accepted or one is pending unanswered
    assign w_owed    = w_req_hs | (fetch_data_ready & ~w_dat_hs);
    assign w_consume = dec_consume & dec_window_valid & (dec_byte_incr != 4'd0) & ~redirect_valid;
    assign w_append  = w_dat_hs & (r_state == S_WAIT) & ~redirect_valid;
    assign w_incr    = w_consume ? dec_byte_incr : 4'd0;
    assign w_rem     = r_count - CW'(w_incr);
    assign w_add     = w_append ? CW'(4'd8 - {1'b0, r_skip}) : '0;

    // Bytes above count are kept zero, so shifted-in data can simply be OR-ed in
    assign w_word     = fetch_data >> {r_skip, 3'b000};
    assign w_ins      = {{(BW - 64){1'b0}}, w_word} << {w_rem, 3'b000};
    assign w_next_buf = (r_buf >> {w_incr, 3'b000}) | (w_append ? w_ins : '0);

    for (genvar k = 0; k < 15; k++) begin : g_win
        assign dec_window[k*8 +: 8] = r_buf[k*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_skip  <= '0;
            r_pc    <= '0;
            r_addr  <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
        end else if (redirect_valid) begin
            r_state <= w_owed ? S_DRAIN : S_REQ;
            r_count <= '0;
            r_buf   <= '0;
            r_pc    <= redirect_pc;
            r_addr  <= {redirect_pc[PC_W-1:3], 3'b000};
            r_skip  <= redirect_pc[2:0];
        end else begin
            r_count <= w_rem + w_add;
            r_buf   <= w_next_buf;
            r_pc    <= r_pc + PC_W'(w_incr);
            r_err   <= r_err | (dec_consume & ~w_consume);
            if (w_append)
                r_skip <= '0;
            if (w_req_hs) begin
                r_state <= S_WAIT;
                r_addr  <= r_addr + PC_W'(8);
            end else if (w_dat_hs) begin
                r_state <= S_REQ;
            end
        end
    end
endmodule
